timer_device: RTL and testbench

- Programmable down-counting timer on the CPU's device bus; its interrupt output drives one bit of the CP0 HWInt[5:0] input.
- The CPU programs it with sw/lw through the bridge (word-addressed, 3 registers).
- A 4-state FSM supports one-shot and periodic-reload modes and generates a maskable interrupt request.

---
 rtl/timer_device.sv | 123 ++++++++++++
 tb/tb_timer_device.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// Programmable down-counting bus timer with one-shot/periodic modes and a maskable interrupt.
// Optional count prescaler is enabled by defining TIMER_PRESCALE_EN.
module timer_device #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t             state;
  logic               en;
  logic [1:0]         mode;
  logic               im;
  logic               irq_pend;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;
  logic               tick_hit;
  logic               pend_set;
  logic [31:0]        preset_ext;
  logic [31:0]        count_ext;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned TW = $clog2(PRESCALE);
  logic [TW-1:0] tick;

  assign tick_hit = (tick == TW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick <= '0;
    end else if (state == S_LOAD) begin
      tick <= '0;
    end else if (state == S_CNT && en) begin
      tick <= tick_hit ? '0 : tick + TW'(1);
    end
  end
`else
  assign tick_hit = 1'b1;
`endif

  assign pend_set = (state == S_CNT) && en && tick_hit && (count == '0);
  assign irq      = irq_pend & im;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      irq_pend <= 1'b0;
      preset   <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: if (en) state <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (tick_hit) begin
            if (count == '0) begin
              state    <= S_INT;
              irq_pend <= 1'b1;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
        end
        S_INT: begin
          if (mode == 2'b01) begin
            state    <= S_LOAD;
            irq_pend <= 1'b0;
          end else begin
            en    <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Bus writes come last so the written value beats the FSM's EN clear;
      // a completion on the same edge still latches the interrupt.
      if (we) begin
        case (addr)
          2'd0: begin
            en   <= din[0];
            mode <= din[2:1];
            im   <= din[3];
            if (!pend_set) irq_pend <= 1'b0;
          end
          2'd1:    preset <= din[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    preset_ext             = '0;
    preset_ext[CNT_W-1:0]  = preset;
    count_ext              = '0;
    count_ext[CNT_W-1:0]   = count;
    dout                   = '0;
    case (addr)
      2'd0:    dout = {28'd0, im, mode, en};
      2'd1:    dout = preset_ext;
      2'd2:    dout = count_ext;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device; prescaler-dependent timing follows TIMER_PRESCALE_EN.
module tb_timer_device;

  localparam int unsigned PRESCALE = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_device #(.CNT_W(32), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  // Edges from the CTRL write to irq assertion for PRESET=n.
  function automatic int lat(input int n);
`ifdef TIMER_PRESCALE_EN
    return 2 + (n + 1) * PRESCALE;
`else
    return n + 3;
`endif
  endfunction

  logic [31:0] v;

  initial begin
    rst  = 1'b0;
    we   = 1'b1;
    din  = 32'hFFFF_FFFF;
    addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    we  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check($sformatf("reset_reg%0d", i), v, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // COUNT and reserved addresses ignore writes
    bus_write(2'd2, 32'h55);
    bus_write(2'd3, 32'hAA);
    rd(2'd2, v); check("count_ro", v, 32'd0);
    rd(2'd3, v); check("rsvd_zero", v, 32'd0);

    // One-shot, PRESET=5
    bus_write(2'd1, 32'd5);
    rd(2'd1, v); check("preset_rd", v, 32'd5);
    bus_write(2'd0, 32'h9);
    tick_n(lat(5) - 1);
    check("os_irq_before", {31'd0, irq}, 32'd0);
    tick_n(1);
    check("os_irq_rise", {31'd0, irq}, 32'd1);
    rd(2'd2, v); check("os_count0", v, 32'd0);
    tick_n(3);
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    rd(2'd0, v); check("os_ctrl_en_clr", v, 32'h8);
    bus_write(2'd0, 32'h8);
    check("os_irq_clr", {31'd0, irq}, 32'd0);

`ifndef TIMER_PRESCALE_EN
    // Periodic, PRESET=3: period 6, count 3,2,1,0 then 0 in INT and LOAD
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      int p;
      logic [31:0] ec;
      tick_n(1);
      p  = (k - 2) % 6;
      ec = (k < 2) ? 32'd0 : ((p <= 3) ? 32'(3 - p) : 32'd0);
      check($sformatf("per_irq_e%0d", k), {31'd0, irq}, (k >= 6 && k % 6 == 0) ? 32'd1 : 32'd0);
      rd(2'd2, v);
      check($sformatf("per_cnt_e%0d", k), v, ec);
    end
    rd(2'd0, v); check("per_ctrl", v, 32'hB);
    bus_write(2'd0, 32'h0);
    tick_n(2);
`endif

    // Masked completion, PRESET=2
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    tick_n(lat(2));
    check("mask_irq", {31'd0, irq}, 32'd0);
    rd(2'd2, v); check("mask_count0", v, 32'd0);
    tick_n(2);
    rd(2'd0, v); check("mask_ctrl", v, 32'h0);
    bus_write(2'd0, 32'h8);
    check("mask_unmask_irq", {31'd0, irq}, 32'd0);
    tick_n(2);
    check("mask_unmask_irq2", {31'd0, irq}, 32'd0);

`ifndef TIMER_PRESCALE_EN
    // Stop mid-count, PRESET write during CNT deferred to next LOAD
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    tick_n(2);
    rd(2'd2, v); check("stop_cnt_e2", v, 32'd10);
    bus_write(2'd1, 32'd2);
    rd(2'd2, v); check("stop_cnt_e3", v, 32'd9);
    rd(2'd1, v); check("stop_preset", v, 32'd2);
    tick_n(3);
    rd(2'd2, v); check("stop_cnt_e6", v, 32'd6);
    bus_write(2'd0, 32'h8);
    rd(2'd2, v); check("stop_cnt_e7", v, 32'd5);
    tick_n(4);
    rd(2'd2, v); check("stop_frozen", v, 32'd5);
    check("stop_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, v); check("stop_ctrl", v, 32'h8);
    bus_write(2'd0, 32'h9);
    tick_n(4);
    check("restart_irq_before", {31'd0, irq}, 32'd0);
    tick_n(1);
    check("restart_irq_rise", {31'd0, irq}, 32'd1);
    bus_write(2'd0, 32'h8);
    check("restart_irq_clr", {31'd0, irq}, 32'd0);

    // Boundary: PRESET=0
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    tick_n(2);
    check("p0_irq_before", {31'd0, irq}, 32'd0);
    tick_n(1);
    check("p0_irq_rise", {31'd0, irq}, 32'd1);
`else
    // Boundary with prescaler: PRESET=1 -> irq after edge 10
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h9);
    tick_n(9);
    check("ps_irq_before", {31'd0, irq}, 32'd0);
    tick_n(1);
    check("ps_irq_rise", {31'd0, irq}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
